// File: rtl/axis_loop_tester.sv
// axis_loop_tester
// ----------------
// Loopback packet tester for an AXI-Stream device under test. One start pulse
// sends a packet of cfg_len beats (seed, seed+1, ...) out on the tx master port.
// The returning stream on the rx slave port is checked against seed+j+offset.
// Mismatches are counted in err_count. Byte-enable problems and packet-length
// problems raise sticky flags. These results hold until the next accepted start.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cfg_start             single-cycle start pulse (accepted only in IDLE with cfg_len != 0)
//   cfg_len/seed/offset   packet length, first word, offset the DUT adds per word
//   tx_*                  AXIS master towards the DUT (valid/ready/data/keep/last)
//   rx_*                  AXIS slave from the DUT (valid/ready/data/keep/last)
//   busy, done            run in progress (RUN and DONE), one-cycle completion pulse
//   err_count             saturating data-mismatch counter
//   len_err, keep_err     sticky packet-length and byte-enable error flags
//   timeout               sticky watchdog flag
//
// Optional feature
//   AXIS_LOOP_TESTER_TIMEOUT_EN: when defined, adds a 16-bit receive watchdog.
//   It forces DONE and raises timeout after 16'hFFFF quiet RUN cycles.
//   Without it, timeout is constant 0 and a run waits indefinitely.

module axis_loop_tester #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
    input  logic [DATA_WIDTH-1:0]   cfg_offset,
    output logic                    tx_valid,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic [DATA_WIDTH/8-1:0] tx_keep,
    input  logic                    rx_valid,
    input  logic                    rx_last,
    output logic                    rx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic [DATA_WIDTH/8-1:0] rx_keep,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_count,
    output logic                    len_err,
    output logic                    keep_err,
    output logic                    timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_txIdx;
    logic [LEN_WIDTH-1:0]  r_rxIdx;
    logic [DATA_WIDTH-1:0] r_txData;
    logic [DATA_WIDTH-1:0] r_rxExpect;
    logic                  r_txDone;
    logic                  r_rxDone;
    logic [15:0]           r_errCount;
    logic                  r_lenErr;
    logic                  r_keepErr;

    logic                  w_start;
    logic                  w_txValid;
    logic                  w_rxReady;
    logic                  w_txFire;
    logic                  w_rxFire;
    logic                  w_txIsLast;
    logic                  w_rxAtEnd;
    logic                  w_txDoneNow;
    logic                  w_rxDoneNow;
    logic                  w_timeoutHit;

    assign w_start     = (r_state == IDLE) && cfg_start && (cfg_len != '0);
    assign w_txFire    = w_txValid && tx_ready;
    assign w_rxFire    = w_rxReady && rx_valid;
    assign w_txIsLast  = (r_txIdx == r_len - LEN_WIDTH'(1));
    assign w_rxAtEnd   = (r_rxIdx == r_len - LEN_WIDTH'(1));

    // Completion includes a handshake happening this cycle.
    // DONE is therefore entered on the edge right after the final beat of the later side.
    assign w_txDoneNow = r_txDone || (w_txFire && w_txIsLast);
    assign w_rxDoneNow = r_rxDone || (w_rxFire && (rx_last || w_rxAtEnd));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake-output decode.
    // tx_valid and rx_ready fall as soon as the state leaves RUN.
    // That is what makes a forced timeout drop tx_valid in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_txValid   = 1'b0;
        w_rxReady   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                w_txValid = !r_txDone;
                w_rxReady = !r_rxDone;
                if ((w_txDoneNow && w_rxDoneNow) || w_timeoutHit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Transmit and receive datapaths advance independently.
    // The expected receive word is kept as a running value, seed+offset+j.
    // This avoids needing an adder on the beat index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_len      <= '0;
            r_txIdx    <= '0;
            r_rxIdx    <= '0;
            r_txData   <= '0;
            r_rxExpect <= '0;
            r_txDone   <= 1'b0;
            r_rxDone   <= 1'b0;
            r_errCount <= '0;
            r_lenErr   <= 1'b0;
            r_keepErr  <= 1'b0;
        end else if (w_start) begin
            r_len      <= cfg_len;
            r_txIdx    <= '0;
            r_rxIdx    <= '0;
            r_txData   <= cfg_seed;
            r_rxExpect <= cfg_seed + cfg_offset;
            r_txDone   <= 1'b0;
            r_rxDone   <= 1'b0;
            r_errCount <= '0;
            r_lenErr   <= 1'b0;
            r_keepErr  <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_txFire) begin
                r_txIdx  <= r_txIdx + LEN_WIDTH'(1);
                r_txData <= r_txData + DATA_WIDTH'(1);
                if (w_txIsLast) begin
                    r_txDone <= 1'b1;
                end
            end
            if (w_rxFire) begin
                r_rxIdx    <= r_rxIdx + LEN_WIDTH'(1);
                r_rxExpect <= r_rxExpect + DATA_WIDTH'(1);
                if ((rx_data != r_rxExpect) && (r_errCount != 16'hFFFF)) begin
                    r_errCount <= r_errCount + 16'd1;
                end
                if (rx_keep != '1) begin
                    r_keepErr <= 1'b1;
                end
                if (rx_last || w_rxAtEnd) begin
                    r_rxDone <= 1'b1;
                end
                // rx_last must coincide exactly with the final expected beat.
                if (rx_last != w_rxAtEnd) begin
                    r_lenErr <= 1'b1;
                end
            end
        end
    end

`ifdef AXIS_LOOP_TESTER_TIMEOUT_EN
    logic [15:0] r_tmoCount;
    logic        r_timeout;

    // The watchdog restarts on every rx beat.
    // When it is about to reach 16'hFFFF, the run is forced into DONE on that same edge.
    assign w_timeoutHit = (r_state == RUN) && !w_rxFire && (r_tmoCount == 16'hFFFE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tmoCount <= '0;
            r_timeout  <= 1'b0;
        end else if (w_start) begin
            r_tmoCount <= '0;
            r_timeout  <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_rxFire) begin
                r_tmoCount <= '0;
            end else begin
                r_tmoCount <= r_tmoCount + 16'd1;
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeoutHit = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign tx_valid  = w_txValid;
    assign tx_last   = w_txValid && w_txIsLast;
    assign tx_data   = r_txData;
    assign tx_keep   = '1;
    assign rx_ready  = w_rxReady;
    assign err_count = r_errCount;
    assign len_err   = r_lenErr;
    assign keep_err  = r_keepErr;

endmodule

// File: tb/tb_axis_loop_tester.sv
// tb_axis_loop_tester
// -------------------
// Self-checking bench for axis_loop_tester (DATA_WIDTH=32, LEN_WIDTH=16).
// An rx source replays a planned return stream built from the packet rules:
// word j = seed+j+offset, optionally corrupted, with rx_last placed as planned.
// It uses random valid gaps. A monitor logs tx handshakes, stalls, rx handshakes
// and done pulses. Each test task compares those logs with the packet rules.
// The watchdog scenario is compiled only when AXIS_LOOP_TESTER_TIMEOUT_EN is defined.

module tb_axis_loop_tester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [31:0] cfg_seed = '0;
    logic [31:0] cfg_offset = '0;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic [3:0]  tx_keep;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_ready;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_keep = 4'hF;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic        len_err;
    logic        keep_err;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    axis_loop_tester #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_seed(cfg_seed), .cfg_offset(cfg_offset),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .tx_data(tx_data), .tx_keep(tx_keep),
        .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready), .rx_data(rx_data), .rx_keep(rx_keep),
        .busy(busy), .done(done), .err_count(err_count),
        .len_err(len_err), .keep_err(keep_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Observation logs filled by the monitor
    logic [32:0]  txLog[$];
    int           txHsCycle[$];
    int           rxHsCycle[$];
    logic [36:0]  rxQ[$];
    int           cycle = 0;
    int           donePulses = 0;
    int           doneCycle = -1;
    int           stallViol = 0;
    int           keepBad = 0;
    int           runEntryCycle = -1;
    logic         prevStall = 1'b0;
    logic         prevBusy = 1'b0;
    logic [31:0]  stallData = '0;
    logic         stallLast = 1'b0;
    int           txMode = 0;
    bit           rxEnable = 1'b1;
    bit           rxHs = 1'b0;

    // Expectations computed by runPacket from the packet rules
    int           expErr;
    int           expRxBeats;
    int           expDoneCycle;
    logic         expLenErr;
    logic         expKeepErr;
    bit           timedOut;

    // Monitor: samples on the falling edge.
    // A handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        cycle++;
        if (tx_valid && tx_ready) begin
            txLog.push_back({tx_last, tx_data});
            txHsCycle.push_back(cycle);
            if (tx_keep !== 4'hF) keepBad++;
        end
        if (prevStall && tx_valid && (tx_data !== stallData || tx_last !== stallLast)) stallViol++;
        prevStall = tx_valid && !tx_ready;
        stallData = tx_data;
        stallLast = tx_last;
        if (rx_valid && rx_ready) rxHsCycle.push_back(cycle);
        if (done === 1'b1) begin
            donePulses++;
            doneCycle = cycle;
        end
        if (busy === 1'b1 && !prevBusy) runEntryCycle = cycle;
        prevBusy = (busy === 1'b1);
    end

    // tx_ready driver: 0 = always ready, 1 = toggle every cycle, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (txMode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // rx source: replays rxQ with random gaps.
    // It holds a beat while it waits for ready.
    initial begin
        forever begin
            @(negedge clk);
            rxHs = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            if (rxHs && rxQ.size() > 0) void'(rxQ.pop_front());
            if (rxQ.size() == 0 || !rxEnable) rx_valid = 1'b0;
            else if (!(rx_valid && !rxHs)) rx_valid = ($urandom_range(0, 3) != 0);
            if (rxQ.size() > 0) {rx_keep, rx_last, rx_data} = rxQ[0];
        end
    end

    // Plans and launches one packet, then waits (bounded) for the done pulse
    task automatic runPacket(input int len, input logic [31:0] seed, input logic [31:0] offset,
                             input int lastIdx, input int corruptIdx, input int corruptPct,
                             input int keepBadIdx, input int mode, input bit midStart, input int budget);
        logic [31:0] d;
        int          txEnd;
        int          rxEnd;
        txLog.delete(); txHsCycle.delete(); rxHsCycle.delete(); rxQ.delete();
        donePulses = 0; doneCycle = -1; stallViol = 0; keepBad = 0; runEntryCycle = -1;
        timedOut = 1'b0; expErr = 0;
        expRxBeats = (lastIdx >= 0 && lastIdx < len) ? lastIdx + 1 : len;
        expLenErr  = (lastIdx != len - 1);
        expKeepErr = (keepBadIdx >= 0 && keepBadIdx < expRxBeats);
        for (int j = 0; j < len; j++) begin
            d = seed + 32'(j) + offset;
            if (j == corruptIdx || (corruptPct > 0 && $urandom_range(0, 99) < corruptPct)) begin
                d = d ^ 32'h1;
                if (j < expRxBeats) expErr++;
            end
            rxQ.push_back({(j == keepBadIdx) ? 4'b0111 : 4'hF, 1'(j == lastIdx), d});
        end
        txMode = mode;
        @(posedge clk); #1;
        cfg_len = 16'(len); cfg_seed = seed; cfg_offset = offset; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < budget && donePulses == 0; c++) begin
            @(negedge clk);
            if (midStart) begin
                cfg_start = (c == 3);
                cfg_seed  = ~seed;
            end
        end
        cfg_start = 1'b0;
        if (donePulses == 0) timedOut = 1'b1;
        repeat (4) @(negedge clk);
        txEnd = (txHsCycle.size() >= len) ? txHsCycle[len-1] : -10;
        rxEnd = (rxHsCycle.size() >= expRxBeats && expRxBeats > 0) ? rxHsCycle[expRxBeats-1] : -10;
        expDoneCycle = ((txEnd > rxEnd) ? txEnd : rxEnd) + 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if ({tx_valid, tx_last, rx_ready, busy, done, len_err, keep_err, timeout} !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 00000000", {tx_valid, tx_last, rx_ready, busy, done, len_err, keep_err, timeout}); end
        vectors++; if (err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_err_count: got %0h expected 0", err_count); end
        vectors++; if (tx_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %0h expected 0", tx_data); end
        vectors++; if (tx_keep !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_tx_keep: got %0h expected f", tx_keep); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean();
        runPacket(4, 32'h0, 32'h01010101, 3, -1, 0, -1, 0, 0, 200);
        vectors++; if (timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_done_wait: timed out waiting for done"); end
        vectors++; if (txLog.size() != 4) begin miscompares++; $display("[TB] FAIL clean_beats: got %0d expected 4", txLog.size()); end
        foreach (txLog[i]) begin
            vectors++; if (txLog[i] !== {1'(i == 3), 32'(i)}) begin miscompares++; $display("[TB] FAIL clean_beat%0d: got %0h expected %0h", i, txLog[i], {1'(i == 3), 32'(i)}); end
        end
        vectors++; if (donePulses != 1) begin miscompares++; $display("[TB] FAIL clean_done_count: got %0d expected 1", donePulses); end
        vectors++; if (doneCycle != expDoneCycle) begin miscompares++; $display("[TB] FAIL clean_done_cycle: got %0d expected %0d", doneCycle, expDoneCycle); end
        vectors++; if (err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL clean_err_count: got %0h expected 0", err_count); end
        vectors++; if ({len_err, keep_err, timeout, keepBad != 0} !== 4'b0000) begin miscompares++; $display("[TB] FAIL clean_flags: got %b expected 0000", {len_err, keep_err, timeout, keepBad != 0}); end
        vectors++; if ({busy, rx_ready, tx_valid} !== 3'b000) begin miscompares++; $display("[TB] FAIL clean_idle_after: got %b expected 000", {busy, rx_ready, tx_valid}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] seed = $urandom;
        runPacket(5, seed, 32'h01010101, 4, -1, 0, -1, 1, 0, 300);
        vectors++; if (txLog.size() != 5) begin miscompares++; $display("[TB] FAIL bp_beats: got %0d expected 5", txLog.size()); end
        foreach (txLog[i]) begin
            vectors++; if (txLog[i] !== {1'(i == 4), 32'(seed + 32'(i))}) begin miscompares++; $display("[TB] FAIL bp_beat%0d: got %0h expected %0h", i, txLog[i], {1'(i == 4), 32'(seed + 32'(i))}); end
        end
        vectors++; if (stallViol != 0) begin miscompares++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stallViol); end
        vectors++; if (err_count !== 16'h0 || donePulses != 1) begin miscompares++; $display("[TB] FAIL bp_result: got err %0h done %0d expected err 0 done 1", err_count, donePulses); end
    endtask

    task automatic test_corruption();
        runPacket(4, 32'h1000, 32'h01010101, 3, 2, 0, -1, 0, 0, 200);
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("[TB] FAIL corrupt_err_count: got %0d expected 1", err_count); end
        vectors++; if (donePulses != 1) begin miscompares++; $display("[TB] FAIL corrupt_done: got %0d expected 1", donePulses); end
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("[TB] FAIL corrupt_len_err: got %b expected 0", len_err); end
    endtask

    task automatic test_early_last();
        runPacket(4, 32'h2000, 32'h01010101, 1, -1, 0, -1, 2, 0, 300);
        vectors++; if (len_err !== 1'b1) begin miscompares++; $display("[TB] FAIL early_len_err: got %b expected 1", len_err); end
        vectors++; if (rxHsCycle.size() != 2) begin miscompares++; $display("[TB] FAIL early_rx_beats: got %0d expected 2", rxHsCycle.size()); end
        vectors++; if (txLog.size() != 4) begin miscompares++; $display("[TB] FAIL early_tx_beats: got %0d expected 4", txLog.size()); end
        vectors++; if (donePulses != 1 || doneCycle != expDoneCycle) begin miscompares++; $display("[TB] FAIL early_done: got %0d pulses at %0d expected 1 at %0d", donePulses, doneCycle, expDoneCycle); end
        rxQ.delete();
        repeat (5) @(negedge clk);
        vectors++; if (len_err !== 1'b1) begin miscompares++; $display("[TB] FAIL early_len_err_hold: got %b expected 1", len_err); end
    endtask

    task automatic test_wrap_reset();
        int rxAtReset;
        runPacket(3, 32'hFFFFFFFE, 32'h01010101, 2, -1, 0, -1, 0, 0, 200);
        vectors++; if (txLog.size() != 3) begin miscompares++; $display("[TB] FAIL wrap_beats: got %0d expected 3", txLog.size()); end
        foreach (txLog[i]) begin
            vectors++; if (txLog[i] !== {1'(i == 2), 32'(32'hFFFFFFFE + 32'(i))}) begin miscompares++; $display("[TB] FAIL wrap_beat%0d: got %0h expected %0h", i, txLog[i], {1'(i == 2), 32'(32'hFFFFFFFE + 32'(i))}); end
        end
        vectors++; if (err_count !== 16'h0 || donePulses != 1) begin miscompares++; $display("[TB] FAIL wrap_result: got err %0h done %0d expected err 0 done 1", err_count, donePulses); end
        // Abort a run with reset; returned words are deliberately wrong
        rxQ.delete();
        for (int j = 0; j < 10; j++) rxQ.push_back({4'hF, 1'(j == 9), 32'hBAD00000 + 32'(j)});
        donePulses = 0; txMode = 0;
        @(posedge clk); #1;
        cfg_len = 16'd10; cfg_seed = 32'h5; cfg_offset = 32'h0; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        rxAtReset = rxHsCycle.size();
        vectors++; if ({tx_valid, tx_last, rx_ready, busy, done, len_err, keep_err, timeout} !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_flags: got %b expected 00000000", {tx_valid, tx_last, rx_ready, busy, done, len_err, keep_err, timeout}); end
        vectors++; if (tx_data !== 32'h0 || tx_keep !== 4'hF || err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL midreset_values: got data %0h keep %0h err %0h expected 0 f 0", tx_data, tx_keep, err_count); end
        repeat (30) @(negedge clk);
        vectors++; if (donePulses != 0) begin miscompares++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", donePulses); end
        vectors++; if (rxHsCycle.size() != rxAtReset || err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL midreset_ignore_rx: got %0d beats err %0h expected 0 beats err 0", rxHsCycle.size() - rxAtReset, err_count); end
        rxQ.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_start();
        logic [31:0] seed = $urandom;
        int          busySeen = 0;
        @(posedge clk); #1;
        cfg_len = 16'd0; cfg_seed = 32'h77; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busySeen++;
        end
        vectors++; if (busySeen != 0) begin miscompares++; $display("[TB] FAIL zero_len_start: got %0d busy cycles expected 0", busySeen); end
        runPacket(6, seed, 32'h01010101, 5, -1, 0, -1, 0, 1, 300);
        vectors++; if (txLog.size() != 6) begin miscompares++; $display("[TB] FAIL midstart_beats: got %0d expected 6", txLog.size()); end
        foreach (txLog[i]) begin
            vectors++; if (txLog[i] !== {1'(i == 5), 32'(seed + 32'(i))}) begin miscompares++; $display("[TB] FAIL midstart_beat%0d: got %0h expected %0h", i, txLog[i], {1'(i == 5), 32'(seed + 32'(i))}); end
        end
        vectors++; if (donePulses != 1 || err_count !== 16'h0) begin miscompares++; $display("[TB] FAIL midstart_result: got done %0d err %0h expected 1 0", donePulses, err_count); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int          len = $urandom_range(1, 12);
            logic [31:0] seed = $urandom;
            logic [31:0] off = $urandom;
            int          sel = $urandom_range(0, 3);
            int          lastIdx = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(0, len - 1)) : len - 1;
            int          kIdx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            runPacket(len, seed, off, lastIdx, -1, 25, kIdx, 2, 0, len * 40 + 100);
            vectors++; if (txLog.size() != len) begin miscompares++; $display("[TB] FAIL rand%0d_beats: got %0d expected %0d", t, txLog.size(), len); end
            foreach (txLog[i]) begin
                vectors++; if (txLog[i] !== {1'(i == len - 1), 32'(seed + 32'(i))}) begin miscompares++; $display("[TB] FAIL rand%0d_beat%0d: got %0h expected %0h", t, i, txLog[i], {1'(i == len - 1), 32'(seed + 32'(i))}); end
            end
            vectors++; if (err_count !== 16'(expErr)) begin miscompares++; $display("[TB] FAIL rand%0d_err_count: got %0d expected %0d", t, err_count, expErr); end
            vectors++; if ({len_err, keep_err, timeout} !== {expLenErr, expKeepErr, 1'b0}) begin miscompares++; $display("[TB] FAIL rand%0d_flags: got %b expected %b", t, {len_err, keep_err, timeout}, {expLenErr, expKeepErr, 1'b0}); end
            vectors++; if (rxHsCycle.size() != expRxBeats) begin miscompares++; $display("[TB] FAIL rand%0d_rx_beats: got %0d expected %0d", t, rxHsCycle.size(), expRxBeats); end
            vectors++; if (donePulses != 1 || doneCycle != expDoneCycle) begin miscompares++; $display("[TB] FAIL rand%0d_done: got %0d pulses at %0d expected 1 at %0d", t, donePulses, doneCycle, expDoneCycle); end
            vectors++; if (stallViol != 0) begin miscompares++; $display("[TB] FAIL rand%0d_stall_stable: got %0d changes expected 0", t, stallViol); end
            rxQ.delete();
            repeat (2) @(negedge clk);
        end
    endtask

`ifdef AXIS_LOOP_TESTER_TIMEOUT_EN
    task automatic test_timeout();
        rxEnable = 1'b0;
        runPacket(4, 32'h3000, 32'h01010101, 3, -1, 0, -1, 0, 0, 70000);
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_flag: got %b expected 1", timeout); end
        vectors++; if (donePulses != 1) begin miscompares++; $display("[TB] FAIL timeout_done: got %0d expected 1", donePulses); end
        vectors++; if (doneCycle - runEntryCycle != 65535) begin miscompares++; $display("[TB] FAIL timeout_latency: got %0d expected 65535", doneCycle - runEntryCycle); end
        rxEnable = 1'b1;
        rxQ.delete();
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_backpressure();
        test_corruption();
        test_early_last();
        test_clean();
        test_wrap_reset();
        test_ignored_start();
        test_random();
`ifdef AXIS_LOOP_TESTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
